quadrature_generator: RTL

QUADRATURE_GENERATOR -- requirements
Module: quadrature_generator

---
 rtl/quadrature_generator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/quadrature_generator.sv
// quadrature_generator: converts step requests into a two-channel Gray-coded
// quadrature pattern on (a, b). Each phase is held for at least PHASE_CYCLES
// en ticks, and a signed 16-bit count of the steps emitted is kept.
// Optional index output: define QUADRATURE_GENERATOR_INDEX_EN to drive idx high
// whenever position[INDEX_BITS-1:0] == 0. When it is undefined, idx is tied low.
module quadrature_generator #(
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned INDEX_BITS   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        step_valid,
  input  logic        step_dir,
  output logic        step_ready,
  output logic        a,
  output logic        b,
  output logic        busy,
  output logic [15:0] position,
  output logic        idx
);

  // Reject illegal parameterisations at elaboration time.
  if (PHASE_CYCLES < 1 || PHASE_CYCLES > 65535) begin : g_bad_phase_cycles
    $error("PHASE_CYCLES must be in 1..65535");
  end
  if (INDEX_BITS < 1 || INDEX_BITS > 15) begin : g_bad_index_bits
    $error("INDEX_BITS must be in 1..15");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_e;

  localparam logic [15:0] CNT_RELOAD = 16'(PHASE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  p_q, p_d;
  logic        a_q, a_d;
  logic        b_q, b_d;
  logic [15:0] position_q, position_d;
  logic        accept;

  // Handshake: IDLE always accepts; DWELL accepts only on the final tick of the dwell.
  always_comb begin
    step_ready = reset_n & ((state_q == IDLE) |
                            ((state_q == DWELL) & (cnt_q == 16'd0) & en));
    accept     = step_valid & step_ready;
  end

  // Next-state logic: advance the phase on accept, otherwise count down the dwell.
  always_comb begin
    // NOTE: every signal starts from its held value, so no path can leave it
    // unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    position_d = position_q;
    if (accept) begin
      p_d        = step_dir ? p_q + 2'd1 : p_q - 2'd1;
      position_d = step_dir ? position_q + 16'd1 : position_q - 16'd1;
      cnt_d      = CNT_RELOAD;
      state_d    = DWELL;
    end else if (state_q == DWELL && en) begin
      if (cnt_q == 16'd0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
    // Gray mapping, so a single phase increment flips exactly one channel.
    a_d = p_d[1];
    b_d = p_d[1] ^ p_d[0];
  end

  // State and output registers; reset wins over a simultaneous accept.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      p_q        <= 2'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      position_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      a_q        <= a_d;
      b_q        <= b_d;
      position_q <= position_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = (state_q == DWELL);
  assign position = position_q;

`ifdef QUADRATURE_GENERATOR_INDEX_EN
  logic idx_q, idx_d;

  // Index is derived from the next position, so it lands on the same edge as position.
  always_comb begin
    idx_d = (position_d[INDEX_BITS-1:0] == '0);
  end

  // Index register; position resets to 0, so idx resets high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q <= 1'b1;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;
`else
  assign idx = 1'b0;
`endif

endmodule
